cpu_mem_arbiter: RTL
====================

# cpu_mem_arbiter

Sequential arbiter sharing the CPU's single-port memory between the instruction-fetch requester (I port) and the load/store requester (D port). It sits between the cpu core's fetch and memory-access stages and the memory block. Each grant runs one complete transaction: issue, wait for memory ready, capture read data, then acknowledge. D has priority, and a streak counter guarantees fetch progress.

## Interface
- ADDR_W, 16, address width of all ports
- DATA_W, 16, data width of all ports
- STREAK_MAX, 4, max consecutive D grants while if_req is pending; legal range ≥1

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid with if_ack, held afterwards
- if_ack  out  1  one-cycle completion pulse for I
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid with d_ack, held afterwards
- d_ack  out  1  one-cycle completion pulse for D
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the cycle mem_ready=1
- mem_ready  in  1  memory completes the access this cycle (sampled only while mem_en=1)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACC_I, ACC_D, RESP.
- IDLE decision (uses requests sampled this cycle):
  - if_req & d_req & streak==STREAK_MAX → grant I, streak←0.
  - else d_req → grant D, streak←streak+1 if if_req else 0.
  - else if_req → grant I, streak←0.
  - else stay IDLE, streak unchanged.
- Grant: latch granted address/we/wdata into mem_addr/mem_we/mem_wdata (I: we=0, wdata=0); mem_en←1; go to ACC_I/ACC_D.
- ACC_x: mem_en, mem_addr, mem_we, mem_wdata held constant. On mem_ready=1: mem_en←0, mem_we←0; for reads, capture mem_rdata into if_rdata (ACC_I) or d_rdata (ACC_D); go to RESP with the matching ack←1. On mem_ready=0: stay.
- RESP: exactly one ack high; next state IDLE unconditionally; ack←0.
- D writes leave d_rdata unchanged. if_rdata/d_rdata change only on their own read completion.
- Streak counter width is clog2(STREAK_MAX+1) and never exceeds STREAK_MAX.
- No timeout: if mem_ready never asserts, the block stays in ACC_x indefinitely.
- Requests arriving during ACC_x/RESP are not observed until IDLE.

## Timing
- Reset values: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, streak=0, busy=0.
- All outputs are registered or decoded from registered state (busy).
- Request in IDLE at cycle 0 → mem_en=1 from cycle 1. mem_ready=1 at cycle 1+W → ack high at cycle 2+W, IDLE at cycle 3+W.
- Zero-wait throughput: one transaction per 3 cycles. A requester holding req after ack (new address) is re-arbitrated in the IDLE cycle.
- Requester rule: deassert or update req at the edge ending the ack cycle. Req is never sampled in RESP.
- Reset mid-transaction (any state): next cycle all reset values; in-flight access is abandoned with no ack; memory sees mem_en=0.

## Test plan
- Reset: hold rst 2 cycles with random inputs → every output 0, busy=0; held 0 while rst=1.
- I read, mem_ready tied 1, memory returns 16'hBEEF for addr 16'h0010: if_req at cycle 0 → mem_en=1, mem_addr=16'h0010, mem_we=0 at cycle 1; if_ack=1, if_rdata=16'hBEEF at cycle 2; if_ack=0 at cycle 3.
- D write, addr 16'h0200, wdata 16'h1234, mem_ready high after 3 wait cycles → mem_en high 4 cycles with addr/wdata stable, mem_we=1; d_ack one cycle after mem_ready; d_rdata unchanged from prior value.
- Both requesters continuously requesting, STREAK_MAX=4, mem_ready=1 → grant order D,D,D,D,I,D,D,D,D,I. Exactly one ack per transaction.
- Streak reset check: D alone for 10 transactions, then both requesting → next four grants are D, then I. This confirms the streak counted only while if_req was high.
- rst asserted during ACC_D with mem_ready=0 → next cycle mem_en=0, d_ack never pulses. A subsequent if_req completes normally with 2-cycle latency.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// ============================================================================
// Module   : cpu_mem_arbiter
// Purpose  : Shares one single-port memory between the instruction-fetch (I)
//            and load/store (D) requesters. Each grant runs one complete
//            transaction: issue, wait for ready, capture data, acknowledge.
//            D has priority. A streak counter bounds consecutive D grants
//            while a fetch is waiting, so that fetch always makes progress.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // status
  output logic              busy
);

  localparam int STREAK_W = $clog2(STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;

  // Busy is decoded from the registered state only.
  assign busy = (state != IDLE);

  // Arbitration, transaction sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req && d_req && (streak == STREAK_LIM)) begin
            // Fetch has waited through the maximum D streak: let it in.
            state     <= ACC_I;
            streak    <= '0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (d_req) begin
            // The streak only counts D grants that actually made I wait.
            state     <= ACC_D;
            streak    <= if_req ? (streak + 1'b1) : '0;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (if_req) begin
            state     <= ACC_I;
            streak    <= '0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end

        ACC_I: begin
          if (mem_ready) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
            state    <= RESP;
          end
        end

        ACC_D: begin
          if (mem_ready) begin
            // Writes leave the D read-data register untouched.
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            d_ack  <= 1'b1;
            state  <= RESP;
          end
        end

        RESP: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
